// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 ID/EX control path: opcodes, ALU ops,
// mux selects, the registered control bundle and the MUL/DIV FSM state.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  // M ops are {2'b10, funct3}: mul..mulhu, div..remu
  localparam logic [1:0] ALU_M_PREFIX = 2'b10;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DRAM = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;
  localparam logic [1:0] WD_IMM  = 2'b11;

  localparam logic [2:0] SEXT_I     = 3'b000;
  localparam logic [2:0] SEXT_SHAMT = 3'b001;
  localparam logic [2:0] SEXT_S     = 3'b010;
  localparam logic [2:0] SEXT_U     = 3'b011;
  localparam logic [2:0] SEXT_B     = 3'b100;
  localparam logic [2:0] SEXT_J     = 3'b101;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] wd_sel;
    logic [4:0] alu_op;
    logic       alua_sel;
    logic       alub_sel;
    logic       rf_we;
    logic       dram_we;
    logic [1:0] mem_size;
    logic       mem_uns;
    logic [2:0] sext_op;
    logic [3:0] branch;
    logic [1:0] jump;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ex_ctrl_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_e;

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle,
// plus flags marking multi-cycle multiply and divide operations.
module rv_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] inst,
  output ex_ctrl_t    ctrl,
  output logic        is_mul,
  output logic        is_div
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  logic       bad;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl       = '0;
    ctrl.valid = 1'b1;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    bad        = 1'b0;

    case (opcode)
      OPC_OP: begin
        ctrl.rd    = rd;
        ctrl.rs1   = rs1;
        ctrl.rs2   = rs2;
        ctrl.rf_we = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  ctrl.alu_op = ALU_ADD;
              3'b001:  ctrl.alu_op = ALU_SLL;
              3'b010:  ctrl.alu_op = ALU_SLT;
              3'b011:  ctrl.alu_op = ALU_SLTU;
              3'b100:  ctrl.alu_op = ALU_XOR;
              3'b101:  ctrl.alu_op = ALU_SRL;
              3'b110:  ctrl.alu_op = ALU_OR;
              default: ctrl.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      ctrl.alu_op = ALU_SUB;
            else if (funct3 == 3'b101) ctrl.alu_op = ALU_SRA;
            else                       bad = 1'b1;
          end
          7'b0000001: begin
            if (ENABLE_M) begin
              ctrl.alu_op = {ALU_M_PREFIX, funct3};
              is_mul      = ~funct3[2];
              is_div      = funct3[2];
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end

      OPC_OP_IMM: begin
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rf_we    = 1'b1;
        ctrl.alub_sel = 1'b1;
        ctrl.sext_op  = SEXT_I;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: ctrl.alu_op = ALU_SLTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.alu_op  = ALU_SLL;
            ctrl.sext_op = SEXT_SHAMT;
            bad          = (funct7 != 7'b0000000);
          end
          default: begin
            ctrl.sext_op = SEXT_SHAMT;
            if (funct7 == 7'b0000000)      ctrl.alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) ctrl.alu_op = ALU_SRA;
            else                           bad = 1'b1;
          end
        endcase
      end

      OPC_LOAD: begin
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rf_we    = 1'b1;
        ctrl.wd_sel   = WD_DRAM;
        ctrl.alu_op   = ALU_ADD;
        ctrl.alub_sel = 1'b1;
        ctrl.sext_op  = SEXT_I;
        ctrl.mem_size = funct3[1:0];
        ctrl.mem_uns  = funct3[2];
        bad = (funct3 == 3'b011) || (funct3[2] && funct3[1]);
      end

      OPC_STORE: begin
        ctrl.rs1      = rs1;
        ctrl.rs2      = rs2;
        ctrl.dram_we  = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.alub_sel = 1'b1;
        ctrl.sext_op  = SEXT_S;
        ctrl.mem_size = funct3[1:0];
        bad = funct3[2] || (funct3[1:0] == 2'b11);
      end

      OPC_LUI: begin
        ctrl.rd      = rd;
        ctrl.rf_we   = 1'b1;
        ctrl.wd_sel  = WD_IMM;
        ctrl.sext_op = SEXT_U;
      end

      OPC_AUIPC: begin
        ctrl.rd       = rd;
        ctrl.rf_we    = 1'b1;
        ctrl.alu_op   = ALU_ADD;
        ctrl.alua_sel = 1'b1;
        ctrl.alub_sel = 1'b1;
        ctrl.sext_op  = SEXT_U;
      end

      OPC_JAL: begin
        ctrl.rd      = rd;
        ctrl.rf_we   = 1'b1;
        ctrl.wd_sel  = WD_PC4;
        ctrl.sext_op = SEXT_J;
        ctrl.jump    = 2'b11;
      end

      OPC_JALR: begin
        ctrl.rd       = rd;
        ctrl.rs1      = rs1;
        ctrl.rf_we    = 1'b1;
        ctrl.wd_sel   = WD_PC4;
        ctrl.alu_op   = ALU_ADD;
        ctrl.alub_sel = 1'b1;
        ctrl.sext_op  = SEXT_I;
        ctrl.jump     = 2'b01;
        bad           = (funct3 != 3'b000);
      end

      OPC_BRANCH: begin
        ctrl.rs1     = rs1;
        ctrl.rs2     = rs2;
        ctrl.alu_op  = ALU_SUB;
        ctrl.sext_op = SEXT_B;
        ctrl.branch  = {funct3, 1'b1};
        bad          = (funct3[2:1] == 2'b01);
      end

      default: bad = 1'b1;
    endcase

    if (bad) begin
      ctrl         = '0;
      ctrl.valid   = 1'b1;
      ctrl.illegal = 1'b1;
      is_mul       = 1'b0;
      is_div       = 1'b0;
    end else if (ctrl.rd == 5'd0) begin
      ctrl.rf_we = 1'b0;
    end
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode/control stage: ID/EX bundle register, load-use
// interlock and the IDLE/BUSY sequencer for multi-cycle MUL/DIV in EX.
module id_ctrl_stage
  import rv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic        flush,
  input  logic        hold,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [1:0]  ex_wd_sel,
  output logic [4:0]  ex_alu_op,
  output logic        ex_alua_sel,
  output logic        ex_alub_sel,
  output logic        ex_rf_we,
  output logic        ex_dram_we,
  output logic [1:0]  ex_mem_size,
  output logic        ex_mem_uns,
  output logic [2:0]  ex_sext_op,
  output logic [3:0]  ex_branch,
  output logic [1:0]  ex_jump,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic        ex_illegal,
  output logic        ex_busy
);

  localparam logic [5:0] MUL_REMAIN = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_REMAIN = 6'(DIV_CYCLES - 1);

  ex_ctrl_t   dec, ex_q, ex_d;
  logic       dec_mul, dec_div;
  mdu_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       hazard;

  rv_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .inst   (id_inst),
    .ctrl   (dec),
    .is_mul (dec_mul),
    .is_div (dec_div)
  );

  // Only loads write back from DRAM, so wd_sel identifies them; unused rs are 0.
  assign hazard = ex_q.valid && (ex_q.wd_sel == WD_DRAM) && (ex_q.rd != 5'd0) &&
                  id_valid && ((dec.rs1 == ex_q.rd) || (dec.rs2 == ex_q.rd));

  assign id_ready = rst_n && !flush && !hold && (state_q == ST_IDLE) && !hazard;

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      ex_d    = '0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (hold) begin
      // everything frozen
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) state_d = ST_IDLE;
    end else if (id_valid && !hazard) begin
      ex_d = dec;
      if (dec_mul && MUL_CYCLES > 1) begin
        state_d = ST_BUSY;
        cnt_d   = MUL_REMAIN;
      end else if (dec_div && DIV_CYCLES > 1) begin
        state_d = ST_BUSY;
        cnt_d   = DIV_REMAIN;
      end
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_wd_sel   = ex_q.wd_sel;
  assign ex_alu_op   = ex_q.alu_op;
  assign ex_alua_sel = ex_q.alua_sel;
  assign ex_alub_sel = ex_q.alub_sel;
  assign ex_rf_we    = ex_q.rf_we;
  assign ex_dram_we  = ex_q.dram_we;
  assign ex_mem_size = ex_q.mem_size;
  assign ex_mem_uns  = ex_q.mem_uns;
  assign ex_sext_op  = ex_q.sext_op;
  assign ex_branch   = ex_q.branch;
  assign ex_jump     = ex_q.jump;
  assign ex_rd       = ex_q.rd;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_illegal  = ex_q.illegal;
  assign ex_busy     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode fields, load-use bubble,
// MUL/DIV occupancy, flush/hold/reset in BUSY, and an RV32M-disabled copy.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, flush, hold;
  logic [31:0] id_inst;

  logic       id_ready, ex_valid, ex_alua_sel, ex_alub_sel, ex_rf_we, ex_dram_we;
  logic       ex_mem_uns, ex_illegal, ex_busy;
  logic [1:0] ex_wd_sel, ex_mem_size, ex_jump;
  logic [4:0] ex_alu_op, ex_rd, ex_rs1, ex_rs2;
  logic [2:0] ex_sext_op;
  logic [3:0] ex_branch;

  logic       n_id_ready, n_ex_valid, n_ex_alua_sel, n_ex_alub_sel, n_ex_rf_we, n_ex_dram_we;
  logic       n_ex_mem_uns, n_ex_illegal, n_ex_busy;
  logic [1:0] n_ex_wd_sel, n_ex_mem_size, n_ex_jump;
  logic [4:0] n_ex_alu_op, n_ex_rd, n_ex_rs1, n_ex_rs2;
  logic [2:0] n_ex_sext_op;
  logic [3:0] n_ex_branch;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_NOP  = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_SW   = 32'h0020A223; // sw x2,4(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208063; // beq x1,x2,0
  localparam logic [31:0] I_JAL  = 32'h000000EF; // jal x1,0
  localparam logic [31:0] I_LUI  = 32'h123454B7; // lui x9,0x12345
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_MUL  = 32'h02208433; // mul x8,x1,x2
  localparam logic [31:0] I_DIV  = 32'h0220C3B3; // div x7,x1,x2

  id_ctrl_stage #(.ENABLE_M(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .flush(flush), .hold(hold), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_wd_sel(ex_wd_sel), .ex_alu_op(ex_alu_op), .ex_alua_sel(ex_alua_sel),
    .ex_alub_sel(ex_alub_sel), .ex_rf_we(ex_rf_we), .ex_dram_we(ex_dram_we),
    .ex_mem_size(ex_mem_size), .ex_mem_uns(ex_mem_uns), .ex_sext_op(ex_sext_op),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_illegal(ex_illegal), .ex_busy(ex_busy)
  );

  id_ctrl_stage #(.ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(33)) dut_nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
    .flush(flush), .hold(hold), .id_ready(n_id_ready), .ex_valid(n_ex_valid),
    .ex_wd_sel(n_ex_wd_sel), .ex_alu_op(n_ex_alu_op), .ex_alua_sel(n_ex_alua_sel),
    .ex_alub_sel(n_ex_alub_sel), .ex_rf_we(n_ex_rf_we), .ex_dram_we(n_ex_dram_we),
    .ex_mem_size(n_ex_mem_size), .ex_mem_uns(n_ex_mem_uns), .ex_sext_op(n_ex_sext_op),
    .ex_branch(n_ex_branch), .ex_jump(n_ex_jump), .ex_rd(n_ex_rd), .ex_rs1(n_ex_rs1),
    .ex_rs2(n_ex_rs2), .ex_illegal(n_ex_illegal), .ex_busy(n_ex_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst);
    id_inst  = inst;
    id_valid = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; id_valid = 1'b1; id_inst = I_ADD; flush = 1'b0; hold = 1'b0;
    tick(); tick();
    check("rst_id_ready", id_ready, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_busy",  ex_busy, 0);
    check("rst_rf_we",    ex_rf_we, 0);
    rst_n = 1'b1; id_valid = 1'b0;
    #1 check("post_rst_ready", id_ready, 1);

    issue(I_ADD);
    check("add_valid", ex_valid, 1);
    check("add_aluop", ex_alu_op, 5'b00010);
    check("add_rf_we", ex_rf_we, 1);
    check("add_rd",    ex_rd, 3);
    check("add_rs",    {ex_rs1, ex_rs2}, {5'd1, 5'd2});

    issue(I_LW);
    check("lw_wd_sel", ex_wd_sel, 2'b01);
    check("lw_size",   ex_mem_size, 2'b10);
    check("lw_alu",    {ex_alu_op, ex_alub_sel}, {5'b00010, 1'b1});
    id_inst = I_ADD6;
    #1 check("lu_ready_low", id_ready, 0);
    tick();
    check("lu_bubble", ex_valid, 0);
    check("lu_ready_back", id_ready, 1);
    tick();
    check("lu_add_issued", {ex_valid, ex_rd}, {1'b1, 5'd6});

    issue(I_LW);
    id_inst = I_NOP;
    #1 check("lw_nop_no_hazard", id_ready, 1);
    tick();
    check("nop_x0_suppress", {ex_valid, ex_rf_we}, {1'b1, 1'b0});

    issue(I_SW);
    check("sw_ctrl", {ex_dram_we, ex_rf_we, ex_rd, ex_rs2, ex_sext_op},
                     {1'b1, 1'b0, 5'd0, 5'd2, 3'b010});
    issue(I_BEQ);
    check("beq_ctrl", {ex_branch, ex_alu_op, ex_sext_op, ex_rs1},
                      {4'b0001, 5'b00110, 3'b100, 5'd1});
    issue(I_JAL);
    check("jal_ctrl", {ex_jump, ex_wd_sel, ex_rd, ex_rs1, ex_sext_op},
                      {2'b11, 2'b10, 5'd1, 5'd0, 3'b101});
    issue(I_LUI);
    check("lui_ctrl", {ex_wd_sel, ex_sext_op, ex_rd, ex_rf_we},
                      {2'b11, 3'b011, 5'd9, 1'b1});
    issue(I_BAD);
    check("bad_opcode", {ex_valid, ex_illegal, ex_rf_we, ex_dram_we}, 4'b1100);

    issue(I_MUL);
    check("mul_ctrl", {ex_alu_op, ex_illegal, ex_rf_we, ex_busy},
                      {5'b10000, 1'b0, 1'b1, 1'b1});
    check("nom_mul_illegal", {n_ex_illegal, n_ex_rf_we, n_ex_busy}, 3'b100);
    id_valid = 1'b0;
    #1 check("mul_busy_ready", id_ready, 0);
    tick();
    check("mul_done", {ex_busy, ex_valid, ex_alu_op, id_ready},
                      {1'b0, 1'b1, 5'b10000, 1'b1});

    issue(I_DIV);
    check("div_start_busy", ex_busy, 1);
    id_inst = I_ADD;
    n = 0;
    while (ex_busy && n < 40) begin
      n++;
      tick();
    end
    check("div_busy_cycles", n, 32);
    check("div_ready_after", id_ready, 1);
    tick();
    check("div_next_issue", {ex_busy, ex_alu_op, ex_rd}, {1'b0, 5'b00010, 5'd3});

    issue(I_DIV);
    id_valid = 1'b0;
    repeat (12) tick();
    check("flush_cnt20", dut.cnt_q, 20);
    flush = 1'b1;
    #1 check("flush_ready_low", id_ready, 0);
    tick();
    flush = 1'b0;
    #1 check("flush_result", {ex_valid, ex_busy, id_ready}, 3'b001);

    issue(I_DIV);
    id_valid = 1'b0;
    tick(); tick();
    hold = 1'b1;
    repeat (3) tick();
    check("hold_cnt", dut.cnt_q, 30);
    check("hold_bundle", {ex_valid, ex_busy, ex_alu_op, ex_rd, id_ready},
                         {1'b1, 1'b1, 5'b10100, 5'd7, 1'b0});
    hold = 1'b0;

    rst_n = 1'b0;
    #1 check("async_rst", {ex_valid, ex_busy, ex_alu_op, ex_rd, ex_rf_we, id_ready}, 0);
    rst_n = 1'b1;
    tick();
    check("after_rst", {ex_valid, ex_busy, id_ready}, 3'b001);

    id_inst = I_ADD; id_valid = 1'b1; flush = 1'b1;
    tick();
    check("flush_kills_accept", ex_valid, 0);
    flush = 1'b0; id_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered decode/control stage for the pipelined RV32 core. It replaces the purely combinational decoder with one that:
- decodes full RV32I plus optional RV32M,
- registers the control bundle into the ID/EX boundary,
- detects load-use hazards,
- sequences multi-cycle MUL/DIV occupancy of EX.

Sits between the IF/ID register and the EX stage. It drives the front-end stall and receives the branch flush.

## Interface
- `ENABLE_M`, 1 — 1: decode RV32M; 0: M encodings flagged illegal.
- `MUL_CYCLES`, 2 — EX occupancy of MUL* ops, range 1..8.
- `DIV_CYCLES`, 33 — EX occupancy of DIV*/REM* ops, range 1..63.
- `clk` in 1 — the one clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `id_valid` in 1 — IF/ID holds an instruction.
- `id_inst` in 32 — instruction word.
- `flush` in 1 — taken branch/jump resolved in EX; kill ID and the bundle being written.
- `hold` in 1 — global freeze (memory wait).
- `id_ready` out 1 — instruction accepted this cycle; IF/ID advances only when `id_valid & id_ready`.
- `ex_valid` out 1 — bundle valid (0 = bubble).
- `ex_wd_sel` out 2 — 00 alu, 01 dram, 10 pc+4, 11 imm.
- `ex_alu_op` out 5 — ALU operation; see Operation.
- `ex_alua_sel` out 1 — ALU A = pc (auipc).
- `ex_alub_sel` out 1 — ALU B = imm.
- `ex_rf_we` out 1 — register-file write enable.
- `ex_dram_we` out 1 — data-memory write enable.
- `ex_mem_size` out 2 — 00 byte, 01 half, 10 word.
- `ex_mem_uns` out 1 — zero-extend load.
- `ex_sext_op` out 3 — 000 I, 001 shamt, 010 S, 011 U, 100 B, 101 J.
- `ex_branch` out 4 — `{funct3, is_branch}`.
- `ex_jump` out 2 — `{is_jal, is_jalr|is_jal}`.
- `ex_rd`, `ex_rs1`, `ex_rs2` out 5 each — register indices; rs fields are 0 when that operand is unused.
- `ex_illegal` out 1 — unsupported encoding.
- `ex_busy` out 1 — multi-cycle op occupying EX.

## Operation
- **Opcodes decoded:** OP, OP-IMM, LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH.
  - Any other opcode, or an M encoding with `ENABLE_M`=0: `ex_illegal`=1, `rf_we`=0, `dram_we`=0.
- **ALU op codes:**
  - and 00000, or 00001, add 00010, slt 00011, sltu 00100, xor 00101, sub 00110, sll 01000, srl 01010, sra 01011.
  - mul 10000, mulh 10001, mulhsu 10010, mulhu 10011, div 10100, divu 10101, rem 10110, remu 10111.
  - Branches use sub.
  - Loads, stores, jalr and auipc use add.
- **x0 suppression:** `rf_we`=0 when rd=x0.
- **Load-use hazard:** the bundle register holds a valid load with rd≠0, and the ID instruction reads that rd via rs1 or rs2. Response: `id_ready`=0 and insert one bubble.
- **Multi-cycle FSM:**
  - States IDLE and BUSY, with a 6-bit down-counter `cnt`.
  - Accepting an M op with latency L>1: bundle written, state→BUSY, `cnt`=L-1.
  - In BUSY: `id_ready`=0, bundle held unchanged, `ex_busy`=1, `cnt` decrements.
  - `cnt`=1: next state IDLE.
- **Priority, per cycle:** reset > flush > hold > BUSY > load-use > accept.
  - flush: bundle → bubble, FSM → IDLE, `cnt`=0, `id_ready`=0.
  - hold: every register is frozen and `id_ready`=0.
  - No accept (`id_valid`=0, or a hazard): next bundle is a bubble.

## Timing
- Decode→bundle latency is 1 cycle. `id_ready` is combinational from current state, hazard, `flush` and `hold`.
- **Reset values:**
  - All `ex_*` outputs 0, including `ex_valid`, `ex_busy`, `ex_illegal`.
  - FSM IDLE, `cnt`=0.
  - `id_ready` while reset is asserted: 0.
- **M-op occupancy:** an M op holds EX exactly L cycles (first cycle plus L-1 busy cycles). Back-to-back M ops therefore issue L cycles apart. L=1 never enters BUSY.
- **flush in BUSY:** terminates the op immediately; IDLE the next cycle.
- **hold in BUSY:** freezes `cnt`.
- **rst_n deassertion mid-operation:** resumes from reset state; no partial bundle is retained.

## Structure
- Shared package `rv_ctrl_pkg`:
  - opcode constants, ALU op codes, `wd_sel`/`sext_op`/`mem_size` encodings;
  - the bundle struct `ex_ctrl_t`;
  - the FSM enum.
- One sub-module, `rv_decode` (combinational): `id_inst` → `ex_ctrl_t` + `is_mul` + `is_div`.
  - The top level holds the bundle register, hazard logic and FSM.

## Test plan
- **Decode:** `add x3,x1,x2` (0x002081B3) with `id_valid`=1 → next cycle `ex_valid`=1, `alu_op`=00010, `rf_we`=1, `ex_rd`=3.
- **Load-use:** `lw x5,0(x1)` then `add x6,x5,x2` → `id_ready`=0 for 1 cycle, one bubble, then the add issues.
- **Divide:** `div x7,x1,x2` with `DIV_CYCLES`=33 → `ex_busy`=1 for 32 cycles, next instruction accepted on cycle 33 after the div.
- **Flush:** `flush` during BUSY with `cnt`=20 → next cycle `ex_valid`=0, `ex_busy`=0, `id_ready`=1.
- **Illegal M:** `ENABLE_M`=0 with `mul` → `ex_illegal`=1, `rf_we`=0. Opcode 0x7F → `ex_illegal`=1.
- **Reset/hold:** `rst_n` low mid-DIV → all outputs 0 asynchronously. `hold`=1 for 3 cycles → bundle and `cnt` unchanged.
